// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with per-channel holding registers,
// explicit or round-robin routing, and a saturating drop counter for out-of-range selects.
module demux_stream_1ton #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [SEL_W-1:0]         cur_sel,
    output logic [N_OUT-1:0]         out_valid,
    input  logic [N_OUT-1:0]         out_ready,
    output logic [N_OUT*DATA_W-1:0]  out_data,
    output logic [7:0]               drop_cnt,
    output logic                     err
);

    logic [SEL_W-1:0] rr_ptr;
    logic             in_range;
    logic             sel_free;
    logic             accept;
    logic [N_OUT-1:0] load;

    always_comb begin
        cur_sel  = mode ? rr_ptr : in_sel;
        in_range = 32'(cur_sel) < N_OUT;
        sel_free = 1'b0;
        load     = '0;
        // a channel is free when empty or draining this very cycle
        for (int i = 0; i < N_OUT; i++) begin
            if (cur_sel == SEL_W'(i)) begin
                sel_free = !out_valid[i] || out_ready[i];
                load[i]  = in_valid && sel_free;
            end
        end
        in_ready = in_range ? sel_free : 1'b1;
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
            rr_ptr    <= '0;
            drop_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (load[i]) begin
                    out_valid[i]                 <= 1'b1;
                    out_data[i*DATA_W +: DATA_W] <= in_data;
                end else if (out_valid[i] && out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            if (accept && mode) begin
                rr_ptr <= (rr_ptr == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr + SEL_W'(1);
            end
            // out-of-range words are sunk; only explicit mode can reach this
            if (accept && !in_range) begin
                err <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Checks an 8-channel and a 6-channel demux, driven by the same stimulus,
// against a per-channel occupancy model (directed steps followed by random traffic).
module tb_demux_stream_1ton;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic [2:0]  in_sel = '0;
    logic [7:0]  out_ready = '0;

    logic        in_ready_a, in_ready_b;
    logic [2:0]  cur_sel_a, cur_sel_b;
    logic [7:0]  out_valid_a;
    logic [5:0]  out_valid_b;
    logic [63:0] out_data_a;
    logic [47:0] out_data_b;
    logic [7:0]  drop_cnt_a, drop_cnt_b;
    logic        err_a, err_b;

    int checks = 0;
    int errors = 0;

    // reference model: per design d (0 = 8 channels, 1 = 6 channels)
    bit         mv[2][8];
    logic [7:0] md[2][8];
    int         mrr[2];
    int         mdrop[2];
    bit         merr[2];
    bit         was_rst;

    always #5 clk = ~clk;

    demux_stream_1ton #(.DATA_W(8), .N_OUT(8), .SEL_W(3)) dut_a (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_sel(in_sel), .cur_sel(cur_sel_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .drop_cnt(drop_cnt_a), .err(err_a)
    );

    demux_stream_1ton #(.DATA_W(8), .N_OUT(6), .SEL_W(3)) dut_b (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_sel(in_sel), .cur_sel(cur_sel_b), .out_valid(out_valid_b),
        .out_ready(out_ready[5:0]), .out_data(out_data_b), .drop_cnt(drop_cnt_b), .err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nout(int d);
        return (d == 0) ? 8 : 6;
    endfunction

    function automatic int esel(int d);
        return mode ? mrr[d] : int'(in_sel);
    endfunction

    function automatic bit erdy(int d);
        int s;
        s = esel(d);
        if (s >= nout(d)) return 1'b1;
        return !mv[d][s] || out_ready[s];
    endfunction

    task automatic step();
        int   s;
        bit   acc;
        logic [7:0] ev;
        logic [7:0] od;
        #1;
        chk("in_ready_a", 32'(in_ready_a), 32'(erdy(0)));
        chk("in_ready_b", 32'(in_ready_b), 32'(erdy(1)));
        chk("cur_sel_a", 32'(cur_sel_a), esel(0));
        chk("cur_sel_b", 32'(cur_sel_b), esel(1));
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int c = 0; c < 8; c++) begin
                    mv[d][c] = 1'b0;
                    md[d][c] = '0;
                end
                mrr[d] = 0;
                mdrop[d] = 0;
                merr[d] = 1'b0;
            end else begin
                s   = esel(d);
                acc = in_valid && erdy(d);
                for (int c = 0; c < nout(d); c++)
                    if (mv[d][c] && out_ready[c]) mv[d][c] = 1'b0;
                if (acc) begin
                    if (s < nout(d)) begin
                        mv[d][s] = 1'b1;
                        md[d][s] = in_data;
                    end else begin
                        if (mdrop[d] < 255) mdrop[d]++;
                        merr[d] = 1'b1;
                    end
                    if (mode) mrr[d] = (mrr[d] + 1) % nout(d);
                end
            end
        end
        was_rst = rst;
        #1;
        for (int d = 0; d < 2; d++) begin
            ev = '0;
            for (int c = 0; c < nout(d); c++) ev[c] = mv[d][c];
            if (d == 0) begin
                chk("out_valid_a", 32'(out_valid_a), 32'(ev));
                chk("drop_cnt_a", 32'(drop_cnt_a), mdrop[0]);
                chk("err_a", 32'(err_a), 32'(merr[0]));
            end else begin
                chk("out_valid_b", 32'(out_valid_b), 32'(ev[5:0]));
                chk("drop_cnt_b", 32'(drop_cnt_b), mdrop[1]);
                chk("err_b", 32'(err_b), 32'(merr[1]));
            end
            for (int c = 0; c < nout(d); c++) begin
                if (mv[d][c] || was_rst) begin
                    if (d == 0) od = out_data_a[c*8 +: 8];
                    else        od = out_data_b[c*8 +: 8];
                    chk($sformatf("out_data_%0d_ch%0d", d, c), 32'(od), 32'(mv[d][c] ? md[d][c] : 8'h00));
                end
            end
        end
    endtask

    task automatic drive(input bit m, input bit v, input logic [2:0] sel,
                         input logic [7:0] data, input logic [7:0] rdy);
        mode = m;
        in_valid = v;
        in_sel = sel;
        in_data = data;
        out_ready = rdy;
        step();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 8; c++) begin
                mv[d][c] = 1'b0;
                md[d][c] = '0;
            end
            mrr[d] = 0;
            mdrop[d] = 0;
            merr[d] = 1'b0;
        end
        was_rst = 1'b0;
        @(posedge clk);
        #1;

        // reset for two cycles
        rst = 1'b1;
        drive(1, 0, 0, 0, 8'hFF);
        drive(1, 0, 0, 0, 8'hFF);
        rst = 1'b0;
        chk("reset_valid_a", 32'(out_valid_a), 0);
        chk("reset_rr_a", 32'(cur_sel_a), 0);

        // explicit routing, back-to-back; channels 6/7 are dropped by the 6-channel design
        for (int k = 0; k < 8; k++) drive(0, 1, 3'(k), 8'hA0 + 8'(k), 8'hFF);
        drive(0, 0, 0, 0, 8'hFF);
        chk("drop_two_b", 32'(drop_cnt_b), 2);
        chk("err_set_b", 32'(err_b), 1);

        // backpressure on channel 3
        drive(0, 1, 3, 8'h55, 8'hF7);
        drive(0, 1, 3, 8'h66, 8'hF7);
        chk("bp_stall_a", 32'(in_ready_a), 0);
        drive(0, 1, 3, 8'h66, 8'hF7);
        drive(0, 1, 4, 8'h77, 8'hF7);
        chk("bp_ch4_a", 32'(out_data_a[39:32]), 32'h77);
        drive(0, 1, 3, 8'h66, 8'hFF);
        chk("bp_reload_a", 32'(out_data_a[31:24]), 32'h66);

        // round-robin wrap, then a stall cycle holds the pointer
        for (int k = 1; k <= 10; k++) drive(1, 1, 0, 8'(k), 8'hFF);
        chk("rr_wrap_a", 32'(cur_sel_a), 2);
        drive(1, 0, 0, 0, 8'hFF);
        chk("rr_hold_a", 32'(cur_sel_a), 2);
        for (int k = 11; k <= 14; k++) drive(1, 1, 0, 8'(k), 8'hFF);

        // drop counter saturation on the 6-channel design
        for (int k = 0; k < 300; k++) drive(0, 1, 3'(6 + (k % 2)), 8'(k), 8'hFF);
        chk("drop_sat_b", 32'(drop_cnt_b), 255);

        // mid-operation reset: rr at 5, channels 1 and 2 held
        rst = 1'b1;
        drive(1, 0, 0, 0, 8'hFF);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) drive(1, 1, 0, 8'h30 + 8'(k), 8'hFF);
        drive(0, 1, 1, 8'hC1, 8'h00);
        drive(0, 1, 2, 8'hC2, 8'h00);
        mode = 1'b1;
        #1;
        chk("rr_five_a", 32'(cur_sel_a), 5);
        rst = 1'b1;
        drive(1, 0, 0, 0, 8'h00);
        rst = 1'b0;
        chk("midrst_valid_a", 32'(out_valid_a), 0);
        chk("midrst_rr_a", 32'(cur_sel_a), 0);
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 8'hFF);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive(1'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom),
                  8'($urandom), 8'($urandom) | 8'($urandom));
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
